// File: rtl/dly_sched_pkg.sv
// dly_sched_pkg: shared definitions for the millisecond delay scheduler.
//   state_t  - scheduler FSM states (IDLE, LOAD, RUN, DONE)
//   T1MS_DEF - prescaler terminal count for a 1 ms period at 50 MHz
//   ch_w()   - width of a channel index for a given channel count
package dly_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [15:0] T1MS_DEF = 16'd49_999;

  function automatic int unsigned ch_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: millisecond prescaler for the shared delay engine.
//   CLK  in  system clock
//   RSTn in  asynchronous active-low reset
//   clr  in  synchronous clear; holds the prescaler at 0 while high
//   tick out one-cycle pulse on the cycle the prescaler wraps from T1MS_VAL
module ms_tick_gen
  import dly_sched_pkg::*;
#(
  parameter logic [15:0] T1MS_VAL = T1MS_DEF
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic clr,
  output logic tick
);

  logic [15:0] presc;

  assign tick = !clr && (presc == T1MS_VAL);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      presc <= '0;
    end else if (clr || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 16'd1;
    end
  end

endmodule

// File: rtl/ms_delay_sched.sv
// ms_delay_sched: round-robin scheduler sharing one ms delay engine among NCH
// requesters. The winner's delay is latched at grant; a one-cycle done pulse
// returns to that channel when the delay expires.
//   CLK    in  system clock (50 MHz)
//   RSTn   in  asynchronous active-low reset
//   req    in  [NCH]        level request, held until done
//   nms    in  [NCH*NMS_W]  packed per-channel delay in ms, sampled at grant
//   grant  out [NCH]        one-hot, high from LOAD through DONE
//   done   out [NCH]        one-cycle pulse at delay expiry
//   busy   out              high whenever not IDLE
//   cur_ch out [CW]         granted channel index, holds when idle
// Build option: DLY_SCHED_CH0_PRIO_EN gives channel 0 priority at arbitration.
module ms_delay_sched
  import dly_sched_pkg::*;
#(
  parameter int unsigned NCH      = 4,
  parameter logic [15:0] T1MS_VAL = T1MS_DEF,
  parameter int unsigned NMS_W    = 16,
  localparam int unsigned CW      = ch_w(NCH)
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic [NCH-1:0]       req,
  input  logic [NCH*NMS_W-1:0] nms,
  output logic [NCH-1:0]       grant,
  output logic [NCH-1:0]       done,
  output logic                 busy,
  output logic [CW-1:0]        cur_ch
);

  localparam logic [NMS_W-1:0] ONE = NMS_W'(1);

  state_t             state, state_d;
  logic [CW-1:0]      ptr, ptr_inc, win, ch_d;
  logic [NMS_W-1:0]   nms_sel, nms_lat, ms_cnt;
  logic [NCH-1:0]     ch_oh, grant_d, done_d;
  logic               abort, tick, presc_clr;

  assign nms_sel   = nms[cur_ch*NMS_W +: NMS_W];
  assign abort     = ((state == LOAD) || (state == RUN)) && !req[cur_ch];
  assign ptr_inc   = (cur_ch == CW'(NCH - 1)) ? '0 : cur_ch + CW'(1);
  assign presc_clr = (state != RUN);

  ms_tick_gen #(.T1MS_VAL(T1MS_VAL)) u_tick (
    .CLK  (CLK),
    .RSTn (RSTn),
    .clr  (presc_clr),
    .tick (tick)
  );

  // First requester at or after the pointer, scanning with wraparound.
  always_comb begin
    win = ptr;
    for (int unsigned i = NCH; i > 0; i--) begin
      if (req[(32'(ptr) + i - 1) % NCH]) begin
        win = CW'((32'(ptr) + i - 1) % NCH);
      end
    end
`ifdef DLY_SCHED_CH0_PRIO_EN
    if (req[0]) begin
      win = '0;
    end
`endif
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Outputs are registered from the next state so grant/done/busy line up
  // with the state they describe.
  always_comb begin
    state_d = state;
    ch_d    = cur_ch;
    case (state)
      IDLE: begin
        if (|req) begin
          state_d = LOAD;
          ch_d    = win;
        end
      end
      LOAD: begin
        if (abort)               state_d = IDLE;
        else if (nms_sel == '0)  state_d = DONE;
        else                     state_d = RUN;
      end
      RUN: begin
        // Expire on the tick that would bring ms_cnt up to the target.
        if (abort)                                     state_d = IDLE;
        else if (tick && ((ms_cnt + ONE) == nms_lat))  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ch_oh   = NCH'(1) << ch_d;
    grant_d = (state_d != IDLE) ? ch_oh : '0;
    done_d  = (state_d == DONE) ? ch_oh : '0;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ptr     <= '0;
      cur_ch  <= '0;
      grant   <= '0;
      done    <= '0;
      busy    <= 1'b0;
      nms_lat <= '0;
      ms_cnt  <= '0;
    end else begin
      cur_ch <= ch_d;
      grant  <= grant_d;
      done   <= done_d;
      busy   <= (state_d != IDLE);
      if (state == LOAD) begin
        nms_lat <= nms_sel;
        ms_cnt  <= '0;
      end else if ((state == RUN) && tick) begin
        ms_cnt <= ms_cnt + ONE;
      end
      if ((state == DONE) || abort) begin
        ptr <= ptr_inc;
      end
    end
  end

endmodule

// File: doc/ms_delay_sched.md
Name: ms_delay_sched

Overview:
- Shares one millisecond delay engine between NCH requesters in the FCU fabric (sensor power-up waits, LED/beeper timing, retry back-off).
- Arbitrates requests round-robin and latches the winner's delay length.
- Runs the ms prescaler and counter for the winner, then returns a one-cycle done pulse to that requester only.
- Replaces per-client free-running delay instances; one timer is active at a time.

Parameters:
- NCH, 4: number of requester channels (2..8).
- T1MS_VAL, 16'd49_999: prescaler terminal count; 1 ms = T1MS_VAL+1 CLK cycles (50 MHz).
- NMS_W, 16: width of each channel's ms delay field.

Ports:
- CLK  in  1  system clock, 50 MHz.
- RSTn  in  1  asynchronous, active-low reset.
- req  in  NCH  level request per channel; held high until that channel's done.
- nms  in  NCH*NMS_W  packed delay values; channel i occupies bits [i*NMS_W +: NMS_W]; sampled only at grant.
- grant  out  NCH  one-hot; high for the granted channel from LOAD through DONE.
- done  out  NCH  one-cycle pulse to the granted channel when its delay expires.
- busy  out  1  high in every state other than IDLE.
- cur_ch  out  $clog2(NCH)  index of the granted channel; holds its last value when idle.

Behaviour:
- Reset (async, RSTn low):
  - State = IDLE; grant, done, busy, cur_ch = 0.
  - Round-robin pointer = 0; prescaler = 0; ms counter = 0; latched nms = 0.
- IDLE:
  - If any req bit is high, pick the first requesting channel at or after the pointer, wrapping modulo NCH.
  - Go to LOAD next cycle.
- LOAD (1 cycle):
  - grant[ch] = 1, cur_ch = ch, busy = 1.
  - Latch nms[ch]; clear prescaler and ms counter.
  - If the latched nms == 0, go to DONE; otherwise go to RUN.
- RUN:
  - Prescaler increments each cycle and wraps to 0 at T1MS_VAL.
  - On the wrap cycle, ms counter increments.
  - When the ms counter equals latched nms, go to DONE.
  - Total time from LOAD entry to DONE entry = nms*(T1MS_VAL+1)+1 cycles.
- DONE (1 cycle):
  - done[ch] = 1 and grant[ch] = 1 in this cycle.
  - Pointer = (ch+1) mod NCH; next state IDLE, where grant drops.
- Abort:
  - If req[ch] falls while in LOAD or RUN, go to IDLE next cycle.
  - No done pulse; grant drops; pointer still advances to ch+1.
- Back-to-back:
  - A requester whose req is still high after its done is re-arbitrated as a new request.
  - Under round-robin it waits behind the other pending channels.
- Request sampling:
  - Requests arriving during RUN are not sampled until IDLE.
  - nms changes after LOAD are ignored.
- Counter widths:
  - Prescaler is 16 bits; the ms counter is NMS_W bits.
  - The ms counter cannot wrap because the comparison ends the run at nms ≤ 2^NMS_W−1.
- Outputs are registered; done and grant are never high for a non-granted channel.

Optional Feature:
- Macro DLY_SCHED_CH0_PRIO_EN.
- Defined: channel 0 wins arbitration in IDLE whenever req[0] is high, regardless of the pointer. A RUN in progress is not preempted. The pointer is updated as normal.
- Undefined: pure round-robin for all channels.

Decomposition:
- Shared package dly_sched_pkg:
  - State encoding constants: IDLE, LOAD, RUN, DONE.
  - Default T1MS_VAL for 50 MHz.
  - clog2 helper constant for cur_ch width.
- One natural sub-module, ms_tick_gen:
  - Prescaler with synchronous clear input.
  - Outputs a 1-cycle tick on the wrap cycle.
  - The scheduler FSM counts ticks.

Test Plan (simulations use T1MS_VAL=9):
- Single request, ch1 req with nms=3: grant[1] rises 1 cycle after req; done[1] pulses exactly 31 cycles after LOAD entry; busy falls the cycle after done.
- Zero delay, ch2 req with nms=0: LOAD then DONE; done[2] high 2 cycles after req; no RUN cycles.
- Contention, req=4'b1111, all nms=1: grants in order ch0, ch1, ch2, ch3, each done 11 cycles after its LOAD; then ch0 again if still requesting.
- Abort, ch3 nms=5, req[3] dropped 20 cycles into RUN: idle within 1 cycle; no done[3]; next pending ch0 granted with pointer wrapped.
- Reset mid-run, RSTn low for 1 cycle during RUN: all outputs 0 immediately; after release ch0 is granted first.
- With DLY_SCHED_CH0_PRIO_EN, ch0 done and req=4'b0011 held: ch0 is re-granted ahead of ch1 on every arbitration.
